axi_pmp_err_responder: RTL and testbench
========================================

# axi_pmp_err_responder

AXI4 error responder that terminates transactions denied by the AXI IO-PMP. It sits on the denied-path branch behind the PMP check and acts as an AXI slave endpoint. It completes every denied write and read protocol-correctly with an error response, and never forwards anything downstream. It keeps one write and one read in flight at a time and handles the two directions independently.

## Interface
- DATA_WIDTH, 64, R data width in bits
- ID_WIDTH, 8, AXI ID width
- ERR_RESP, 2'b10, response code on B and every R beat (SLVERR; 2'b11 selects DECERR)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_awid  in  ID_WIDTH  write ID
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bid  out  ID_WIDTH  echoed write ID
- s_axi_bresp  out  2  always ERR_RESP
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_arlen  in  8  burst length minus one
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rid  out  ID_WIDTH  echoed read ID
- s_axi_rdata  out  DATA_WIDTH  always zero
- s_axi_rresp  out  2  always ERR_RESP
- s_axi_rlast  out  1  final beat marker
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- All other AW/W/AR fields (addr, size, burst, data, strb, user, etc.) are ignored and not ported.

## Operation
- An init flop is cleared by reset and set on the first clk edge after rst_n rises. Every ready output is ANDed with it.
- Write FSM states: W_IDLE, W_DRAIN, W_RESP.
  - W_IDLE: awready=1. On awvalid&&awready, capture awid and go to W_DRAIN.
  - W_DRAIN: wready=1. Every handshaked beat is discarded. On wvalid&&wready&&wlast, go to W_RESP.
  - W_RESP: bvalid=1, bid=captured ID, bresp=ERR_RESP. On bready, go to W_IDLE.
  - W beats that arrive before AW stall, because wready=0 outside W_DRAIN (legal per AXI).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, capture arid and arlen, and clear the 8-bit beat counter.
  - R_DATA: rvalid=1, rid=captured ID, rdata=0, rresp=ERR_RESP, rlast=(cnt==len).
  - On rvalid&&rready: if rlast, go to R_IDLE; otherwise increment cnt.
  - The comparison happens before the increment, so arlen=255 yields exactly 256 beats with no counter wrap.
- The read and write FSMs are fully independent. Simultaneous AW and AR handshakes are both accepted in the same cycle.
- Outputs hold stable while valid is high and ready is low (AXI stability rule).

## Timing
- Reset values: all valid outputs 0, all ready outputs 0, rlast 0, bid/rid 0, rdata 0, bresp/rresp ERR_RESP, both FSMs in IDLE.
- Reset asserted mid-transaction aborts it. The next transaction starts clean, with no stale ID or count.
- awready/arready are first 1 in the cycle after the first clk edge following reset release.
- Write path, counting from the AW handshake at cycle 0:
  - wready is high from cycle 1.
  - bvalid rises in the cycle after the wlast handshake.
  - awready returns in the cycle after the B handshake.
- Read path, counting from the AR handshake at cycle 0:
  - rvalid is high from cycle 1.
  - With rready held high, beat k is delivered in cycle k+1, and rlast is in cycle arlen+1.
  - arready returns in the cycle after the last beat.
- Throughput: one bubble cycle between back-to-back transactions per direction.
- All outputs come straight from registers or the FSM state. There is no combinational valid-to-ready path.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with awvalid=arvalid=1 -> no handshake occurs, all valid/ready outputs 0. Release reset -> awready=arready=1 one cycle after the first edge.
- Single write: awid=0x3A, one W beat with wlast=1 -> exactly one B with bid=0x3A and bresp=2'b10, arriving the cycle after the W handshake.
- Read burst: arid=0x11, arlen=3, rready=1 -> four beats in cycles 1-4, each with rid=0x11, rdata=0, rresp=2'b10; rlast only on the 4th beat.
- Max burst with backpressure: arlen=255, rready toggled randomly -> exactly 256 beats, rlast only on the last, rid/rlast stable while stalled.
- Concurrency: AW (id 0x05, 8-beat W) and AR (id 0x06, arlen=1) in the same cycle, with bready held low for 10 cycles -> both complete with correct IDs, and the R burst is unaffected by the B stall.
- Mid-burst reset: assert rst_n=0 during beat 2 of an arlen=7 read -> rvalid drops immediately. After reset, a new read with arid=0x22 and arlen=0 returns a single beat with rid=0x22 and rlast=1.

Source files
------------

// File: rtl/axi_pmp_err_responder.sv
// Terminates AXI4 transactions denied by the IO-PMP: drains writes, returns zero-data reads,
// and answers every transfer with ERR_RESP. One write and one read in flight, independent paths.
module axi_pmp_err_responder #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter logic [1:0]  ERR_RESP   = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic                r_init;
    w_state_t            r_wstate;
    w_state_t            w_wstate_nxt;
    r_state_t            r_rstate;
    r_state_t            w_rstate_nxt;
    logic [ID_WIDTH-1:0] r_awid;
    logic [ID_WIDTH-1:0] r_arid;
    logic [7:0]          r_arlen;
    logic [7:0]          r_cnt;
    logic                w_aw_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_at_last;

    assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
    assign w_r_hs    = s_axi_rvalid && s_axi_rready;
    assign w_at_last = (r_cnt == r_arlen);

    assign s_axi_bid   = r_awid;
    assign s_axi_bresp = ERR_RESP;
    assign s_axi_rid   = r_arid;
    assign s_axi_rdata = '0;
    assign s_axi_rresp = ERR_RESP;

    // Holds all readys low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi_awready = r_init;
                if (s_axi_awvalid && r_init) w_wstate_nxt = W_DRAIN;
            end
            W_DRAIN: begin
                s_axi_wready = r_init;
                if (s_axi_wvalid && r_init && s_axi_wlast) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi_arready = r_init;
                if (s_axi_arvalid && r_init) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = w_at_last;
                if (s_axi_rready && w_at_last) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Compare precedes increment, so arlen=255 ends at cnt=255 without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awid  <= '0;
            r_arid  <= '0;
            r_arlen <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_aw_hs) r_awid <= s_axi_awid;
            if (w_ar_hs) begin
                r_arid  <= s_axi_arid;
                r_arlen <= s_axi_arlen;
                r_cnt   <= '0;
            end else if (w_r_hs && !w_at_last) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_pmp_err_responder.sv
// Randomized bench for axi_pmp_err_responder: transaction scoreboard plus per-transaction timing checks.
module tb_axi_pmp_err_responder;

    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 8;
    localparam logic [1:0]  ERR = 2'b10;
    localparam int unsigned TMO = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] s_axi_awid;
    logic          s_axi_awvalid, s_axi_awready;
    logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid, s_axi_bready;
    logic [IW-1:0] s_axi_arid;
    logic [7:0]    s_axi_arlen;
    logic          s_axi_arvalid, s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Scoreboard: IDs awaiting W drain, IDs awaiting B, and the flat list of expected R beats.
    logic [IW-1:0] awq[$];
    logic [IW-1:0] bq[$];
    logic [IW-1:0] rq_id[$];
    bit            rq_last[$];

    logic          p_bstall, p_rstall, p_rlast;
    logic [IW-1:0] p_bid, p_rid;

    axi_pmp_err_responder #(
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .ERR_RESP  (ERR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_awid   (s_axi_awid),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wlast  (s_axi_wlast),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bid    (s_axi_bid),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_arid   (s_axi_arid),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes are observed mid-cycle; a valid&&ready seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            awq.delete(); bq.delete(); rq_id.delete(); rq_last.delete();
            p_bstall = 1'b0;
            p_rstall = 1'b0;
        end else begin
            if (p_bstall) begin
                chk("b_hold_valid", s_axi_bvalid, 1);
                chk("b_hold_id", s_axi_bid, p_bid);
            end
            if (p_rstall) begin
                chk("r_hold_valid", s_axi_rvalid, 1);
                chk("r_hold_id", s_axi_rid, p_rid);
                chk("r_hold_last", s_axi_rlast, p_rlast);
            end
            if (s_axi_wready) chk("wready_needs_aw", awq.size() > 0, 1);
            if (s_axi_awvalid && s_axi_awready) awq.push_back(s_axi_awid);
            if (s_axi_wvalid && s_axi_wready && s_axi_wlast && awq.size() > 0)
                bq.push_back(awq.pop_front());
            if (s_axi_bvalid) begin
                chk("b_expected", bq.size() > 0, 1);
                chk("bresp", s_axi_bresp, ERR);
                if (s_axi_bready && bq.size() > 0) chk("bid", s_axi_bid, bq.pop_front());
            end
            if (s_axi_arvalid && s_axi_arready)
                for (int k = 0; k <= int'(s_axi_arlen); k++) begin
                    rq_id.push_back(s_axi_arid);
                    rq_last.push_back(k == int'(s_axi_arlen));
                end
            if (s_axi_rvalid) begin
                chk("r_expected", rq_id.size() > 0, 1);
                chk("rresp", s_axi_rresp, ERR);
                chk("rdata", s_axi_rdata, 0);
                if (s_axi_rready && rq_id.size() > 0) begin
                    chk("rid", s_axi_rid, rq_id.pop_front());
                    chk("rlast", s_axi_rlast, rq_last.pop_front());
                end
            end
            p_bstall = s_axi_bvalid && !s_axi_bready;
            p_bid    = s_axi_bid;
            p_rstall = s_axi_rvalid && !s_axi_rready;
            p_rid    = s_axi_rid;
            p_rlast  = s_axi_rlast;
        end
    end

    task automatic do_write(input logic [IW-1:0] id, input int unsigned nbeats, input int unsigned bhold);
        int unsigned n;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b1;
        s_axi_awid    = id;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < TMO);
        chk("aw_hs", s_axi_awready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        chk("wready_cycle1", s_axi_wready, 1);
        for (int unsigned b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk); #1;
            s_axi_wvalid = 1'b1;
            s_axi_wlast  = (b == nbeats - 1);
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < TMO);
            chk("w_hs", s_axi_wready, 1);
            @(posedge clk); #1;
            s_axi_wvalid = 1'b0;
            s_axi_wlast  = 1'b0;
        end
        @(negedge clk);
        chk("bvalid_after_wlast", s_axi_bvalid, 1);
        repeat (bhold) @(posedge clk);
        @(posedge clk); #1;
        s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < TMO);
        chk("b_hs", s_axi_bvalid, 1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", s_axi_bvalid, 0);
        chk("awready_return", s_axi_awready, 1);
    endtask

    // rand_rr=0 holds rready high and checks beat-per-cycle timing.
    task automatic do_read(input logic [IW-1:0] id, input logic [7:0] len, input bit rand_rr);
        int unsigned n, cyc, beats;
        bit done;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1;
        s_axi_arid    = id;
        s_axi_arlen   = len;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < TMO);
        chk("ar_hs", s_axi_arready, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        cyc = 0; beats = 0; done = 1'b0;
        while (!done && cyc < 4 * TMO) begin
            s_axi_rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (cyc == 0) chk("rvalid_cycle1", s_axi_rvalid, 1);
            if (s_axi_rvalid && s_axi_rready) begin
                beats++;
                if (s_axi_rlast) done = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b0;
        chk("r_done", done, 1);
        chk("r_beats", beats, int'(len) + 1);
        if (!rand_rr) chk("r_cycles", cyc, int'(len) + 1);
        @(negedge clk);
        chk("rvalid_drop", s_axi_rvalid, 0);
        chk("arready_return", s_axi_arready, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_axi_awid = '0; s_axi_awvalid = 1'b1;
        s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;

        repeat (5) begin
            @(negedge clk);
            chk("rst_awready", s_axi_awready, 0);
            chk("rst_arready", s_axi_arready, 0);
        end
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rlast", s_axi_rlast, 0);
        chk("rst_bid", s_axi_bid, 0);
        chk("rst_rid", s_axi_rid, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_bresp", s_axi_bresp, ERR);
        chk("rst_rresp", s_axi_rresp, ERR);

        @(posedge clk); #1;
        rst_n = 1'b1;
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("init_awready_low", s_axi_awready, 0);
        chk("init_arready_low", s_axi_arready, 0);
        @(negedge clk);
        chk("init_awready", s_axi_awready, 1);
        chk("init_arready", s_axi_arready, 1);

        do_write(8'h3A, 1, 2);
        do_read(8'h11, 8'd3, 1'b0);

        fork
            do_write(8'h05, 8, 10);
            do_read(8'h06, 8'd1, 1'b0);
        join

        fork
            begin
                repeat (6) do_write(IW'($urandom), $urandom_range(1, 8), $urandom_range(0, 4));
            end
            begin
                repeat (5) do_read(IW'($urandom), 8'($urandom_range(0, 15)), 1'b1);
                do_read(IW'($urandom), 8'd255, 1'b1);
            end
        join

        // Abort an 8-beat read while beat 2 is on the bus.
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1;
        s_axi_arid    = 8'h5C;
        s_axi_arlen   = 8'd7;
        s_axi_rready  = 1'b1;
        @(negedge clk);
        chk("mb_arready", s_axi_arready, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mb_beat2_valid", s_axi_rvalid, 1);
        #2;
        rst_n = 1'b0;
        s_axi_rready = 1'b0;
        #1;
        chk("mb_rvalid_drop", s_axi_rvalid, 0);
        chk("mb_rlast_drop", s_axi_rlast, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mb_arready_after", s_axi_arready, 1);
        chk("mb_rid_clean", s_axi_rid, 0);
        do_read(8'h22, 8'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("end_awq_empty", awq.size(), 0);
        chk("end_bq_empty", bq.size(), 0);
        chk("end_rq_empty", rq_id.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
